// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM states, SPI mode encodings and the
// slave-select index width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    // Encoded as {cpol, cpha}.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    function automatic int ss_width(input int num_ss);
        return (num_ss <= 1) ? 1 : $clog2(num_ss);
    endfunction

endpackage

// File: rtl/spi_clkgen.sv
// SCLK half-period divider: produces a tick every CLK_DIV cycles while the
// frame is running, and splits SHIFT-phase ticks into leading/trailing strobes.
module spi_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic shift,
    output logic tick,
    output logic lead,
    output logic trail
);

    localparam int CW = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          phase;

    assign tick  = run && (div_cnt == LAST);
    assign lead  = tick && shift && !phase;
    assign trail = tick && shift && phase;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else begin
            if (!run || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            if (!shift)
                phase <= 1'b0;
            else if (tick)
                phase <= !phase;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// Single-frame SPI master: captures a request, drives SS/SCLK/MOSI for one
// DATA_W-bit frame in the requested mode and bit order, and returns the RX word.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_SS  = 1,
    parameter int CLK_DIV = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic [ss_width(NUM_SS)-1:0]   ss_sel,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          lsb_first,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             rx_data,
    output logic                          sclk,
    output logic                          mosi,
    input  logic                          miso,
    output logic [NUM_SS-1:0]             ss_n
);

    localparam int SS_W = ss_width(NUM_SS);
    localparam int BW   = $clog2(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    spi_state_e          state;
    spi_mode_e           mode_r;
    logic                lsb_r;
    logic [DATA_W-1:0]   tx_sr;
    logic [DATA_W-1:0]   rx_sr;
    logic [BW-1:0]       bit_cnt;
    logic [NUM_SS-1:0]   ss_dec;
    logic                run, shift, tick, lead, trail;

    assign run   = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign shift = (state == SHIFT);

    spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .shift (shift),
        .tick  (tick),
        .lead  (lead),
        .trail (trail)
    );

    // An out-of-range index matches no bit, so every select stays high.
    always_comb begin
        // NOTE: default first so every path assigns ss_dec and no latch is inferred.
        ss_dec = '1;
        for (int i = 0; i < NUM_SS; i++)
            if (ss_sel == SS_W'(i))
                ss_dec[i] = 1'b0;
    end

    function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                   input logic lsb, input logic b);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mode_r  <= MODE0;
            lsb_r   <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            ss_n    <= '1;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    mosi <= 1'b0;
                    if (start) begin
                        state   <= SETUP;
                        busy    <= 1'b1;
                        mode_r  <= spi_mode_e'({cpol, cpha});
                        lsb_r   <= lsb_first;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        ss_n    <= ss_dec;
                        // cpha=0 presents the first bit before the first SCLK edge.
                        if (cpha) begin
                            tx_sr <= tx_data;
                        end else begin
                            mosi  <= out_bit(tx_data, lsb_first);
                            tx_sr <= advance(tx_data, lsb_first);
                        end
                    end
                end
                SETUP: begin
                    sclk <= mode_r[1];
                    if (tick)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (tick)
                        sclk <= !sclk;
                    if (lead) begin
                        if (mode_r[0]) begin
                            mosi  <= out_bit(tx_sr, lsb_r);
                            tx_sr <= advance(tx_sr, lsb_r);
                        end else begin
                            rx_sr <= shift_in(rx_sr, lsb_r, miso);
                        end
                    end
                    if (trail) begin
                        if (mode_r[0]) begin
                            rx_sr <= shift_in(rx_sr, lsb_r, miso);
                        end else begin
                            mosi  <= out_bit(tx_sr, lsb_r);
                            tx_sr <= advance(tx_sr, lsb_r);
                        end
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    sclk <= mode_r[1];
                    if (tick) begin
                        state   <= DONE;
                        ss_n    <= '1;
                        done    <= 1'b1;
                        rx_data <= rx_sr;
                        mosi    <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Randomised scoreboard bench for spi_master_core with a behavioural SPI slave
// that reacts to SCLK edges and an expectation queue consumed on each done.
module tb_spi_master_core;
    import spi_pkg::*;

    localparam int DW      = 8;
    localparam int NUM_SS  = 5;
    localparam int CLK_DIV = 2;
    localparam int SS_W    = ss_width(NUM_SS);
    localparam int BUSY_LEN = CLK_DIV * (2 * DW + 2) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [DW-1:0]     tx_data = '0;
    logic [SS_W-1:0]   ss_sel = '0;
    logic              cpol = 1'b0;
    logic              cpha = 1'b0;
    logic              lsb_first = 1'b0;
    logic              busy, done, sclk, mosi, miso;
    logic [DW-1:0]     rx_data;
    logic [NUM_SS-1:0] ss_n;

    spi_master_core #(.DATA_W(DW), .NUM_SS(NUM_SS), .CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tx_data   (tx_data),
        .ss_sel    (ss_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .busy      (busy),
        .done      (done),
        .rx_data   (rx_data),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Behavioural slave: shifts MSB first, reacting only to SCLK transitions while selected.
    logic          loopback = 1'b0;
    logic          fr_cpol = 1'b0;
    logic          fr_cpha = 1'b0;
    logic [DW-1:0] slv_tx = '0;
    logic [DW-1:0] slv_rx = '0;
    logic          slv_miso = 1'b0;
    logic          slv_first = 1'b0;
    logic          prev_sclk = 1'b0;
    logic          prev_act = 1'b0;
    int            slv_sent = 0;
    logic          ss_act;

    assign ss_act = ~(&ss_n);
    assign miso   = loopback ? mosi : (ss_act ? slv_miso : 1'b0);

    always @(sclk or ss_act) begin
        if (ss_act && !prev_act) begin
            slv_rx   = '0;
            slv_sent = 0;
            slv_miso = 1'b0;
            slv_first = 1'b0;
            if (!fr_cpha) begin
                slv_miso = slv_tx[DW-1];
                slv_sent = 1;
            end
        end else if (ss_act && sclk !== prev_sclk) begin
            if ((sclk != fr_cpol) ^ fr_cpha) begin
                if (slv_rx == '0 && slv_sent <= 1) slv_first = mosi;
                slv_rx = {slv_rx[DW-2:0], mosi};
            end else if (slv_sent < DW) begin
                slv_miso = slv_tx[DW-1-slv_sent];
                slv_sent++;
            end
        end
        prev_sclk = sclk;
        prev_act  = ss_act;
    end

    // Scoreboard
    typedef struct {
        logic [DW-1:0]     rx;
        logic [DW-1:0]     slv;
        bit                chk_slv;
        logic [NUM_SS-1:0] ss;
        int                busy_len;
        logic              pol;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   dones_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    task automatic monitor();
        int   busy_run = 0;
        bit   ss_ok = 1'b1;
        bit   after_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_run   = 0;
                ss_ok      = 1'b1;
                after_done = 1'b0;
            end else begin
                if (after_done) begin
                    check("post_done_idle", {busy, done}, 2'b00);
                    after_done = 1'b0;
                end
                if (busy) busy_run++;
                if (busy && !done && sb.size() > 0 && ss_n !== sb[0].ss) ss_ok = 1'b0;
                if (done) begin
                    dones_total++;
                    check("done_expected", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("rx_data", rx_data, e.rx);
                        check("busy_len", busy_run, e.busy_len);
                        check("ss_during_frame", ss_ok, 1'b1);
                        check("ss_released_at_done", ss_n, {NUM_SS{1'b1}});
                        check("sclk_idle_at_done", sclk, e.pol);
                        if (e.chk_slv) check("slave_rx", slv_rx, e.slv);
                    end
                    after_done = 1'b1;
                end
                if (!busy) begin
                    busy_run = 0;
                    ss_ok    = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_within_budget", busy, 1'b0);
    endtask

    task automatic set_mode(input spi_mode_e m);
        cpol    = m[1];
        cpha    = m[0];
        fr_cpol = m[1];
        fr_cpha = m[0];
        repeat (2) @(posedge clk);
        #1;
        check("sclk_idle_before", sclk, m[1]);
    endtask

    task automatic issue(input logic [DW-1:0] tx, input logic [DW-1:0] stx, input logic lsb,
                         input logic [SS_W-1:0] sel, input bit loop);
        exp_t              e;
        bit                hit;
        logic [NUM_SS-1:0] one;
        one       = 1;
        hit       = (int'(sel) < NUM_SS);
        tx_data   = tx;
        slv_tx    = stx;
        lsb_first = lsb;
        ss_sel    = sel;
        loopback  = loop;
        e.rx       = loop ? tx : (hit ? (lsb ? rev(stx) : stx) : '0);
        e.slv      = lsb ? rev(tx) : tx;
        e.chk_slv  = hit;
        e.ss       = hit ? ~(one << sel) : {NUM_SS{1'b1}};
        e.busy_len = BUSY_LEN;
        e.pol      = cpol;
        sb.push_back(e);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        int   n;
        int   dones_before;
        bit   busy_seen;
        spi_mode_e m;

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ss_n", ss_n, {NUM_SS{1'b1}});
        check("reset_sclk", sclk, 1'b0);
        check("reset_mosi", mosi, 1'b0);
        check("reset_rx_data", rx_data, '0);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // Mode 0 loopback
        set_mode(MODE0);
        issue(8'hA5, 8'h00, 1'b0, 3'd0, 1'b1);
        wait_idle();
        check("mode0_single_done", dones_total, 1);

        // Mode 3 with slave
        set_mode(MODE3);
        issue(8'hC3, 8'h3C, 1'b0, 3'd0, 1'b0);
        wait_idle();
        @(posedge clk); #1;
        check("mode3_sclk_idle_after", sclk, 1'b1);

        // LSB first, mode 1
        set_mode(MODE1);
        issue(8'h01, 8'h96, 1'b1, 3'd0, 1'b0);
        wait_idle();
        check("lsb_first_bit", slv_first, 1'b1);

        // Slave 2 selected, start pulse mid-frame ignored
        set_mode(MODE0);
        issue(DW'($urandom), DW'($urandom), 1'b0, 3'd2, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_data = DW'($urandom);
        ss_sel  = 3'd4;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
        busy_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            busy_seen |= busy;
        end
        check("midframe_start_ignored", busy_seen, 1'b0);

        // Out-of-range select
        issue(DW'($urandom), DW'($urandom), 1'b0, 3'd5, 1'b0);
        wait_idle();

        // Back-to-back frames
        set_mode(MODE0);
        issue(8'h11, 8'h5A, 1'b0, 3'd1, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_first_done", done, 1'b1);
        @(posedge clk); #1;
        check("b2b_gap_idle", busy, 1'b0);
        issue(8'h22, 8'hE7, 1'b0, 3'd1, 1'b0);
        check("b2b_accept", busy, 1'b1);
        wait_idle();

        // Randomised frames
        for (int k = 0; k < 16; k++) begin
            m = spi_mode_e'($urandom_range(0, 3));
            set_mode(m);
            issue(DW'($urandom), DW'($urandom), 1'($urandom), SS_W'($urandom_range(0, 7)),
                  1'($urandom));
            wait_idle();
        end

        // Reset mid-frame around bit 4
        set_mode(MODE2);
        issue(DW'($urandom), DW'($urandom), 1'b0, 3'd1, 1'b0);
        repeat (CLK_DIV * 9) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_ss_n", ss_n, {NUM_SS{1'b1}});
        check("abort_sclk", sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_rx_data", rx_data, '0);
        sb.delete();
        dones_before = dones_total;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_done", dones_total, dones_before);
        check("abort_stays_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
